snoopy_frame_scheduler: RTL and testbench

SNOOPY_FRAME_SCHEDULER -- requirements
Module: snoopy_frame_scheduler

---
 rtl/snoopy_frame_scheduler.sv | 79 +++++++
 tb/tb_snoopy_frame_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_frame_scheduler.sv
// snoopy_frame_scheduler: per-frame erase/update/draw sequencer for the snoopy and obstacle sprites
// clock, reset               : sole clock, synchronous active-high reset
// jump_btn, pause            : synchronised jump level, frame-skip level
// draw_done                  : one-cycle completion strobe from the shared draw engine
// draw_req, draw_sel         : draw engine request (held until done), sprite (0 snoopy, 1 obstacle)
// draw_erase                 : 1 = erase with background colour, 0 = draw sprite
// update_en, jump_out        : one-cycle per-sprite position enables, one-cycle jump pulse
// frame_count, overrun, busy : completed frames, sticky late-tick flag, not-idle status
module snoopy_frame_scheduler #(
    parameter int FRAME_DIV = 833333,
    parameter int CNT_W     = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jump_btn,
    input  logic       pause,
    input  logic       draw_done,
    output logic       draw_req,
    output logic       draw_sel,
    output logic       draw_erase,
    output logic [1:0] update_en,
    output logic       jump_out,
    output logic [7:0] frame_count,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ERASE, WAIT_E, UPDATE, DRAW, WAIT_D, NEXT} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] div;
    logic sel, jump_prev, jump_pending;
    logic tick, jump_edge;
    assign tick = div == CNT_W'(FRAME_DIV - 1);
    assign jump_edge = jump_btn & ~jump_prev;
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (tick && !pause) ? ERASE : IDLE;
            ERASE:   state_nxt = WAIT_E;
            WAIT_E:  state_nxt = draw_done ? UPDATE : WAIT_E;
            UPDATE:  state_nxt = DRAW;
            DRAW:    state_nxt = WAIT_D;
            WAIT_D:  state_nxt = draw_done ? NEXT : WAIT_D;
            NEXT:    state_nxt = sel ? IDLE : ERASE;
            default: state_nxt = IDLE;
        endcase
    end
    // jump_out also sees a same-cycle edge so a press landing on the snoopy update is not deferred a frame
    always_comb begin
        draw_req   = (state == ERASE) || (state == WAIT_E) || (state == DRAW) || (state == WAIT_D);
        draw_erase = (state == ERASE) || (state == WAIT_E);
        draw_sel   = draw_req & sel;
        update_en  = (state == UPDATE) ? (sel ? 2'b10 : 2'b01) : 2'b00;
        jump_out   = (state == UPDATE) && !sel && (jump_pending || jump_edge);
        busy       = state != IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            div          <= '0;
            sel          <= 1'b0;
            jump_prev    <= 1'b0;
            jump_pending <= 1'b0;
            frame_count  <= 8'd0;
            overrun      <= 1'b0;
        end else begin
            div          <= tick ? '0 : div + 1'b1;
            jump_prev    <= jump_btn;
            jump_pending <= (jump_pending | jump_edge) & ~jump_out;
            // a tick while busy is dropped, only flagged
            if (tick && state != IDLE) overrun <= 1'b1;
            if (state == IDLE && tick && !pause) sel <= 1'b0;
            else if (state == NEXT) sel <= 1'b1;
            if (state == NEXT && sel) frame_count <= frame_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_snoopy_frame_scheduler.sv
// tb_snoopy_frame_scheduler: randomized bench against an operation-queue model of the frame scheduler
module tb_snoopy_frame_scheduler;
    localparam int FD = 8;
    localparam int REQ = 0, UPD = 1, NXT = 2;
    logic clock = 1'b0;
    logic reset = 1'b1, jump_btn = 1'b0, pause = 1'b0, draw_done = 1'b0;
    logic draw_req, draw_sel, draw_erase, jump_out, overrun, busy;
    logic [1:0] update_en;
    logic [7:0] frame_count;

    snoopy_frame_scheduler #(.FRAME_DIV(FD), .CNT_W(20)) dut (
        .clock(clock), .reset(reset), .jump_btn(jump_btn), .pause(pause), .draw_done(draw_done),
        .draw_req(draw_req), .draw_sel(draw_sel), .draw_erase(draw_erase), .update_en(update_en),
        .jump_out(jump_out), .frame_count(frame_count), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    // a frame is a list of operations; each draw request lasts one issue cycle plus its wait cycles
    typedef struct {
        int   kind;
        logic sel;
        logic erase;
        bit   started;
        int   waited;
        int   delay;
    } op_t;
    op_t ops[$];
    int m_cyc, dmin, dmax, spur_pct;
    logic m_pend, m_prev, m_over;
    logic [7:0] m_frames;
    logic [15:0] exp_v, act_v;
    int checks = 0, passed = 0;

    function automatic op_t mk_op(input int k, input logic s, input logic e);
        op_t o;
        o.kind = k; o.sel = s; o.erase = e; o.started = 0; o.waited = 0; o.delay = 0;
        return o;
    endfunction

    task automatic push_frame();
        for (int s = 0; s < 2; s++) begin
            ops.push_back(mk_op(REQ, s == 1, 1'b1));
            ops.push_back(mk_op(UPD, s == 1, 1'b0));
            ops.push_back(mk_op(REQ, s == 1, 1'b0));
            ops.push_back(mk_op(NXT, s == 1, 1'b0));
        end
    endtask

    function automatic logic [15:0] expected(input logic btn);
        logic req, s, er, jo, bz;
        logic [1:0] ue;
        req = 0; s = 0; er = 0; jo = 0; ue = 2'b00;
        bz = ops.size() != 0;
        if (bz) begin
            if (ops[0].kind == REQ) begin
                req = 1; s = ops[0].sel; er = ops[0].erase;
            end
            if (ops[0].kind == UPD) begin
                ue = ops[0].sel ? 2'b10 : 2'b01;
                jo = !ops[0].sel && (m_pend || (btn && !m_prev));
            end
        end
        return {req, s, er, ue, jo, bz, m_over, m_frames};
    endfunction

    task automatic model_reset();
        ops.delete();
        m_cyc = 0; m_pend = 0; m_prev = 0; m_over = 0; m_frames = 8'd0;
    endtask

    task automatic do_reset(input logic btn);
        @(negedge clock);
        reset = 1'b1; jump_btn = btn; pause = 1'b0; draw_done = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic apply(input logic btn, input logic pau, input logic frc);
        logic eng;
        @(negedge clock);
        eng = 1'b0;
        if (ops.size() != 0 && ops[0].kind == REQ && ops[0].started) eng = ops[0].waited >= ops[0].delay;
        jump_btn = btn;
        pause = pau;
        draw_done = eng | frc | ($urandom_range(99) < spur_pct);
        #1;
        exp_v = expected(btn);
        act_v = {draw_req, draw_sel, draw_erase, update_en, jump_out, busy, overrun, frame_count};
    endtask

    task automatic commit();
        op_t o;
        logic tick, edg, used;
        @(posedge clock);
        tick = (m_cyc % FD) == FD - 1;
        edg = jump_btn & ~m_prev;
        used = 1'b0;
        if (ops.size() == 0) begin
            if (tick && !pause) push_frame();
        end else begin
            if (tick) m_over = 1'b1;
            o = ops[0];
            if (o.kind == REQ) begin
                if (!o.started) begin
                    o.started = 1;
                    o.delay = $urandom_range(dmax, dmin);
                    ops[0] = o;
                end else if (draw_done) void'(ops.pop_front());
                else begin
                    o.waited++;
                    ops[0] = o;
                end
            end else begin
                if (o.kind == UPD && !o.sel) used = m_pend | edg;
                if (o.kind == NXT && o.sel) m_frames++;
                void'(ops.pop_front());
            end
        end
        m_pend = (m_pend | edg) & ~used;
        m_prev = jump_btn;
        m_cyc++;
    endtask

    task automatic test_reset();
        dmin = 0; dmax = 0; spur_pct = 0;
        do_reset(1'b0);
        repeat (6) begin
            apply(1'b0, 1'b0, 1'b1);
            checks++;
            if (act_v !== exp_v) $display("FAIL reset cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
        end
    endtask

    task automatic test_zero_wait();
        logic [1:0] seq[$];
        logic [1:0] want[4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        logic prev_req = 1'b0;
        dmin = 0; dmax = 0; spur_pct = 0;
        do_reset(1'b0);
        repeat (40) begin
            apply(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL zero_wait cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            if (draw_req && !prev_req) seq.push_back({draw_sel, draw_erase});
            prev_req = draw_req;
            commit();
        end
        #1;
        checks++;
        if (frame_count !== 8'd2) $display("FAIL zero_wait_frames got=%0d want=2", frame_count); else passed++;
        checks++;
        if (seq.size() != 8) $display("FAIL zero_wait_seq_len got=%0d want=8", seq.size()); else passed++;
        for (int i = 0; i < seq.size() && i < 8; i++) begin
            checks++;
            if (seq[i] !== want[i % 4]) $display("FAIL zero_wait_seq[%0d] got=%b want=%b", i, seq[i], want[i % 4]); else passed++;
        end
    endtask

    task automatic test_jump();
        int jn = 0, jc = -1;
        dmin = 0; dmax = 0; spur_pct = 0;
        do_reset(1'b0);
        for (int c = 0; c < 40; c++) begin
            apply(c == 2 || c == 4, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL jump cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            if (jump_out) begin
                jn++;
                jc = c;
                checks++;
                if (update_en !== 2'b01) $display("FAIL jump_coincide got=%b want=01", update_en); else passed++;
            end
            commit();
        end
        checks++;
        if (jn != 1) $display("FAIL jump_count got=%0d want=1", jn); else passed++;
        checks++;
        if (jc != 10) $display("FAIL jump_cycle got=%0d want=10", jc); else passed++;
    endtask

    task automatic test_overrun();
        dmin = 10; dmax = 10; spur_pct = 0;
        do_reset(1'b0);
        repeat (150) begin
            apply(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL overrun cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
        end
        #1;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_flag got=%b want=1", overrun); else passed++;
        checks++;
        if (frame_count !== 8'd2) $display("FAIL overrun_frames got=%0d want=2", frame_count); else passed++;
    endtask

    task automatic test_pause();
        int nreq = 0, jc = -1;
        dmin = 0; dmax = 0; spur_pct = 20;
        do_reset(1'b0);
        for (int c = 0; c < 50; c++) begin
            apply(c == 3, c < 31, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL pause cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            if (c < 31 && draw_req) nreq++;
            if (jump_out) jc = c;
            if (c == 31) begin
                checks++;
                if (frame_count !== 8'd0) $display("FAIL pause_frames got=%0d want=0", frame_count); else passed++;
            end
            commit();
        end
        checks++;
        if (nreq != 0) $display("FAIL pause_req got=%0d want=0", nreq); else passed++;
        checks++;
        if (jc != 34) $display("FAIL pause_jump_cycle got=%0d want=34", jc); else passed++;
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        dmin = 6; dmax = 6; spur_pct = 0;
        do_reset(1'b0);
        for (int c = 0; c < 60 && !hit; c++) begin
            apply(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL mid_reset cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
            hit = ops.size() != 0 && ops[0].kind == REQ && !ops[0].erase && ops[0].started;
        end
        #1;
        checks++;
        if (!hit || draw_req !== 1'b1) $display("FAIL mid_reset_wait_d got=%b want=1", draw_req); else passed++;
        do_reset(1'b1);
        for (int c = 0; c < 30; c++) begin
            apply(1'b1, 1'b0, c == 0);
            checks++;
            if (act_v !== exp_v) $display("FAIL after_reset cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        dmin = 0; dmax = 0; spur_pct = 0;
        do_reset(1'b0);
        while (m_frames != 8'd255 && guard < 5000) begin
            apply(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL wrap cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
            guard++;
        end
        checks++;
        if (guard >= 5000) $display("FAIL wrap_timeout got=%0d want=255", m_frames); else passed++;
        repeat (20) begin
            apply(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL wrap cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
        end
        #1;
        checks++;
        if (frame_count !== 8'd0) $display("FAIL wrap_frames got=%0d want=0", frame_count); else passed++;
        checks++;
        if (overrun !== 1'b1) $display("FAIL wrap_overrun got=%b want=1", overrun); else passed++;
    endtask

    task automatic test_random();
        logic btn = 1'b0, pau = 1'b0;
        dmin = 0; dmax = 4; spur_pct = 15;
        do_reset(1'b0);
        repeat (2000) begin
            if ($urandom_range(9) == 0) btn = ~btn;
            if ($urandom_range(39) == 0) pau = ~pau;
            apply(btn, pau, 1'b0);
            checks++;
            if (act_v !== exp_v) $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, act_v, exp_v); else passed++;
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_jump();
        test_overrun();
        test_pause();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
